if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
IF/ID pipeline register sitting directly downstream of the PC register and instruction memory. Captures the fetched word-address PC and instruction each cycle and presents them to the decode stage. Applies the same stall/bubble controls the PC stage uses:
- holds on load-use hazard
- inserts NOPs on branch and CP0 bubbles
Also tracks branch delay slots and keeps saturating stall/bubble performance counters.

Parameters:
RESET_PC, 30'h000000D, word address loaded into id_PC on reset (byte 0x34).
NOP, 32'h00000000, instruction word driven into ID on any bubble.
CNT_W, 16, width of the performance counters.

Ports:
Clk  in  1  clock; this block updates on posedge (the PC updates on negedge).
Reset  in  1  synchronous, active-high reset.
PC  in  30  word address [31:2] of the instruction currently being fetched.
Instr  in  32  instruction memory read data for PC.
if_valid  in  1  fetch-stage valid from the PC register.
hazard  in  1  load-use stall; hold ID contents.
BranchBubble  in  1  branch-resolution bubble; insert NOP into ID.
cp0Bubble  in  1  exception/eret redirect; flush ID plus one wrong-path fetch.
id_PC  out  30  PC of the instruction in ID.
id_PC4  out  30  id_PC + 1 (word address of PC+4), wraps modulo 2^30.
id_Instr  out  32  instruction in ID.
id_valid  out  1  ID holds a real instruction.
id_isBranch  out  1  combinational decode of id_Instr; qualified by id_valid.
id_inDelaySlot  out  1  ID instruction is the delay slot of a branch/jump.
stall_cnt  out  CNT_W  saturating count of hazard-hold cycles.
bubble_cnt  out  CNT_W  saturating count of NOP-insert cycles.

Behaviour:
- All state updates on posedge Clk. Reset is synchronous and has highest priority.
- Reset values:
  - id_PC=RESET_PC, id_Instr=NOP, id_valid=0
  - id_inDelaySlot=0, pend_ds=0
  - stall_cnt=0, bubble_cnt=0
  - state=RUN
- id_isBranch is asserted (when id_valid=1) for these opcodes:
  - opcode 000100 (beq), 000101 (bne), 000110 (blez), 000111 (bgtz), 000001 (REGIMM)
  - opcode 000010 (j), 000011 (jal)
  - opcode 000000 with funct 001000 (jr) or 001001 (jalr)
- FSM states: RUN, HOLD, FLUSH. Per-cycle priority: Reset > cp0Bubble > hazard > BranchBubble > load.
- cp0Bubble=1 (any state):
  - ID<=NOP, id_valid=0, pend_ds<=0, id_inDelaySlot<=0
  - bubble_cnt++, next state FLUSH
- hazard=1 (no cp0Bubble):
  - all ID registers hold, stall_cnt++, next state HOLD
  - A hazard arriving in FLUSH is held in FLUSH: the pending discard is not lost.
- BranchBubble=1 (no cp0Bubble, no hazard):
  - ID<=NOP, id_valid<=0, bubble_cnt++
  - If the departing ID instruction was a valid branch, pend_ds<=1.
  - Next state RUN.
- FLUSH with no cp0Bubble and no hazard:
  - The presented fetch is wrong-path: discard it, ID<=NOP, bubble_cnt++, next state RUN.
- Load (RUN/HOLD, no controls):
  - id_PC<=PC, id_Instr<=Instr, id_valid<=if_valid
  - id_inDelaySlot<=if_valid & ((id_valid & id_isBranch) | pend_ds)
  - pend_ds cleared when a valid instruction loads.
  - Next state RUN.
- If if_valid=0 on load: id_Instr<=NOP, id_valid<=0, pend_ds retained.
- Counters saturate at all-ones with no wrap. Both counters may never increment in the same cycle.
- Latency: one posedge from fetch to ID visibility. Hold is indefinite while hazard remains high.
- Reset asserted mid-HOLD or mid-FLUSH returns to RUN with reset values on the same edge.

Test Plan:
1. Reset high 2 cycles, then released with PC=0x0D, Instr=0x24080005, if_valid=1 -> during reset id_PC=0x0D, id_valid=0. After the first edge following release: id_Instr=0x24080005, id_PC4=0x0E, id_valid=1.
2. Load beq (0x10000003) at PC 0x10, then addi at PC 0x11 -> at the second load id_inDelaySlot=1; with a following non-branch load it returns to 0.
3. Hazard high 3 cycles while Instr changes -> id_Instr/id_PC unchanged, stall_cnt=3, bubble_cnt=0. Load resumes on the edge after hazard drops.
4. Valid beq in ID, BranchBubble for 1 cycle, then next fetch -> one NOP cycle (id_valid=0, bubble_cnt=1). The next valid instruction has id_inDelaySlot=1 via pend_ds.
5. cp0Bubble 1 cycle, then normal fetches -> two consecutive NOP cycles (cp0 cycle plus FLUSH), bubble_cnt=2. The third fetch loads with id_inDelaySlot=0. Repeat with hazard high during FLUSH -> the FLUSH discard still occurs after hazard drops.
6. Preload stall_cnt to 0xFFFE via 65534 hazard cycles, hold 3 more -> stall_cnt=0xFFFF with no wrap. Then assert Reset -> both counters 0 and state RUN.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched PC/instruction for decode, applying
// load-use hold, branch/CP0 bubbles, delay-slot tracking and stall/bubble counters.
module if_id_reg #(
  parameter logic [29:0] RESET_PC = 30'h000000D,
  parameter logic [31:0] NOP      = 32'h00000000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [29:0]      PC,
  input  logic [31:0]      Instr,
  input  logic             if_valid,
  input  logic             hazard,
  input  logic             BranchBubble,
  input  logic             cp0Bubble,
  output logic [29:0]      id_PC,
  output logic [29:0]      id_PC4,
  output logic [31:0]      id_Instr,
  output logic             id_valid,
  output logic             id_isBranch,
  output logic             id_inDelaySlot,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned PC_W    = 30;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [PC_W-1:0]    id_pc4_q, id_pc4_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;
  logic               id_in_ds_q, id_in_ds_d;
  logic               pend_ds_q, pend_ds_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic               is_branch_c;
  logic [5:0]         opcode_c;
  logic [5:0]         funct_c;

  // Branch/jump decode of the instruction currently in ID
  always_comb begin
    opcode_c    = id_instr_q[31:26];
    funct_c     = id_instr_q[5:0];
    is_branch_c = 1'b0;
    unique case (opcode_c)
      6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111: is_branch_c = 1'b1;
      6'b000000: is_branch_c = (funct_c == 6'b001000) || (funct_c == 6'b001001);
      default:   is_branch_c = 1'b0;
    endcase
    is_branch_c = is_branch_c & id_valid_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= RUN;
      id_pc_q      <= RESET_PC;
      id_pc4_q     <= RESET_PC + PC_W'(1);
      id_instr_q   <= NOP;
      id_valid_q   <= 1'b0;
      id_in_ds_q   <= 1'b0;
      pend_ds_q    <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_instr_q   <= id_instr_d;
      id_valid_q   <= id_valid_d;
      id_in_ds_q   <= id_in_ds_d;
      pend_ds_q    <= pend_ds_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Priority: cp0Bubble > hazard > BranchBubble > FLUSH discard > load
  always_comb begin
    state_d      = state_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_instr_d   = id_instr_q;
    id_valid_d   = id_valid_q;
    id_in_ds_d   = id_in_ds_q;
    pend_ds_d    = pend_ds_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (cp0Bubble) begin
      id_instr_d   = NOP;
      id_valid_d   = 1'b0;
      id_in_ds_d   = 1'b0;
      pend_ds_d    = 1'b0;
      bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble_cnt_q != '1);
      state_d      = FLUSH;
    end else if (hazard) begin
      // A pending FLUSH discard survives the stall
      stall_cnt_d  = stall_cnt_q + CNT_W'(stall_cnt_q != '1);
      state_d      = (state_q == FLUSH) ? FLUSH : HOLD;
    end else if (BranchBubble) begin
      id_instr_d   = NOP;
      id_valid_d   = 1'b0;
      id_in_ds_d   = 1'b0;
      pend_ds_d    = pend_ds_q | is_branch_c;
      bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble_cnt_q != '1);
      state_d      = RUN;
    end else if (state_q == FLUSH) begin
      id_instr_d   = NOP;
      id_valid_d   = 1'b0;
      id_in_ds_d   = 1'b0;
      bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble_cnt_q != '1);
      state_d      = RUN;
    end else begin
      id_pc_d  = PC;
      id_pc4_d = PC + PC_W'(1);
      state_d  = RUN;
      if (if_valid) begin
        id_instr_d = Instr;
        id_valid_d = 1'b1;
        id_in_ds_d = is_branch_c | pend_ds_q;
        pend_ds_d  = 1'b0;
      end else begin
        id_instr_d = NOP;
        id_valid_d = 1'b0;
        id_in_ds_d = 1'b0;
      end
    end
  end

  assign id_PC          = id_pc_q;
  assign id_PC4         = id_pc4_q;
  assign id_Instr       = id_instr_q;
  assign id_valid       = id_valid_q;
  assign id_isBranch    = is_branch_c;
  assign id_inDelaySlot = id_in_ds_q;
  assign stall_cnt      = stall_cnt_q;
  assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: hand-computed vectors for load, hold, bubbles,
// delay-slot tracking, counter saturation and reset.
module tb_if_id_reg;

  logic        clk;
  logic        reset;
  logic [29:0] pc;
  logic [31:0] instr;
  logic        if_valid;
  logic        hazard;
  logic        branch_bubble;
  logic        cp0_bubble;
  logic [29:0] id_pc;
  logic [29:0] id_pc4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_is_branch;
  logic        id_in_ds;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  int unsigned n_vec;
  int unsigned n_miscmp;

  if_id_reg dut (
    .Clk           (clk),
    .Reset         (reset),
    .PC            (pc),
    .Instr         (instr),
    .if_valid      (if_valid),
    .hazard        (hazard),
    .BranchBubble  (branch_bubble),
    .cp0Bubble     (cp0_bubble),
    .id_PC         (id_pc),
    .id_PC4        (id_pc4),
    .id_Instr      (id_instr),
    .id_valid      (id_valid),
    .id_isBranch   (id_is_branch),
    .id_inDelaySlot(id_in_ds),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: outputs sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [29:0] p, input logic [31:0] i, input logic v);
    pc       = p;
    instr    = i;
    if_valid = v;
  endtask

  initial begin
    n_vec = 0;
    n_miscmp = 0;
    reset = 1'b1; hazard = 1'b0; branch_bubble = 1'b0; cp0_bubble = 1'b0;
    fetch(30'h0D, 32'h24080005, 1'b1);

    // Reset and first load
    step(); step();
    chk("rst_pc",     32'(id_pc), 32'h0D);
    chk("rst_pc4",    32'(id_pc4), 32'h0E);
    chk("rst_valid",  32'(id_valid), 32'h0);
    chk("rst_instr",  id_instr, 32'h0);
    chk("rst_stall",  32'(stall_cnt), 32'h0);
    chk("rst_bubble", 32'(bubble_cnt), 32'h0);
    reset = 1'b0;
    step();
    chk("ld0_instr", id_instr, 32'h24080005);
    chk("ld0_pc4",   32'(id_pc4), 32'h0E);
    chk("ld0_valid", 32'(id_valid), 32'h1);
    chk("ld0_ds",    32'(id_in_ds), 32'h0);

    // Branch followed by delay slot
    fetch(30'h10, 32'h10000003, 1'b1); step();
    chk("beq_isbr", 32'(id_is_branch), 32'h1);
    chk("beq_ds",   32'(id_in_ds), 32'h0);
    fetch(30'h11, 32'h20090001, 1'b1); step();
    chk("slot_pc", 32'(id_pc), 32'h11);
    chk("slot_ds", 32'(id_in_ds), 32'h1);
    chk("slot_isbr", 32'(id_is_branch), 32'h0);
    fetch(30'h12, 32'h01095020, 1'b1); step();
    chk("after_ds", 32'(id_in_ds), 32'h0);
    fetch(30'h13, 32'h03E00008, 1'b1); step();
    chk("jr_isbr", 32'(id_is_branch), 32'h1);
    fetch(30'h14, 32'h0C000100, 1'b1); step();
    chk("jal_isbr", 32'(id_is_branch), 32'h1);
    chk("jal_ds",   32'(id_in_ds), 32'h1);
    fetch(30'h15, 32'h10000003, 1'b0); step();
    chk("inv_isbr", 32'(id_is_branch), 32'h0);
    chk("inv_ds",   32'(id_in_ds), 32'h0);
    chk("inv_pc",   32'(id_pc), 32'h15);

    // Load-use hold
    fetch(30'h20, 32'h24A50001, 1'b1); step();
    hazard = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fetch(30'h21 + 30'(k), 32'h2400000A + 32'(k), 1'b1);
      step();
    end
    chk("hold_instr",  id_instr, 32'h24A50001);
    chk("hold_pc",     32'(id_pc), 32'h20);
    chk("hold_stall",  32'(stall_cnt), 32'h3);
    chk("hold_bubble", 32'(bubble_cnt), 32'h0);
    hazard = 1'b0;
    fetch(30'h21, 32'h24A50002, 1'b1); step();
    chk("resume_pc",    32'(id_pc), 32'h21);
    chk("resume_instr", id_instr, 32'h24A50002);

    // Branch bubble sets pending delay slot
    fetch(30'h30, 32'h10000003, 1'b1); step();
    branch_bubble = 1'b1;
    fetch(30'h31, 32'h20090001, 1'b1); step();
    chk("bb_valid",  32'(id_valid), 32'h0);
    chk("bb_instr",  id_instr, 32'h0);
    chk("bb_bubble", 32'(bubble_cnt), 32'h1);
    branch_bubble = 1'b0;
    fetch(30'h32, 32'h200A0002, 1'b1); step();
    chk("pend_valid", 32'(id_valid), 32'h1);
    chk("pend_pc",    32'(id_pc), 32'h32);
    chk("pend_ds",    32'(id_in_ds), 32'h1);
    fetch(30'h33, 32'h10000003, 1'b1); step();
    chk("pend_clr_ds", 32'(id_in_ds), 32'h0);

    // CP0 flush with branch in ID: two NOP cycles, third fetch not a delay slot
    cp0_bubble = 1'b1;
    fetch(30'h34, 32'h20080007, 1'b1); step();
    chk("cp0_valid",  32'(id_valid), 32'h0);
    chk("cp0_bubble", 32'(bubble_cnt), 32'h2);
    cp0_bubble = 1'b0;
    fetch(30'h40, 32'h20080007, 1'b1); step();
    chk("flush_valid",  32'(id_valid), 32'h0);
    chk("flush_instr",  id_instr, 32'h0);
    chk("flush_bubble", 32'(bubble_cnt), 32'h3);
    fetch(30'h41, 32'h20080008, 1'b1); step();
    chk("post_flush_valid", 32'(id_valid), 32'h1);
    chk("post_flush_pc",    32'(id_pc), 32'h41);
    chk("post_flush_ds",    32'(id_in_ds), 32'h0);

    // CP0 flush with hazard during FLUSH
    cp0_bubble = 1'b1; step();
    cp0_bubble = 1'b0; hazard = 1'b1;
    fetch(30'h42, 32'h20080009, 1'b1); step(); step();
    chk("fh_valid",  32'(id_valid), 32'h0);
    chk("fh_stall",  32'(stall_cnt), 32'h5);
    chk("fh_bubble", 32'(bubble_cnt), 32'h4);
    hazard = 1'b0; step();
    chk("fh_discard_valid",  32'(id_valid), 32'h0);
    chk("fh_discard_bubble", 32'(bubble_cnt), 32'h5);
    fetch(30'h43, 32'h2008000A, 1'b1); step();
    chk("fh_load_valid", 32'(id_valid), 32'h1);
    chk("fh_load_pc",    32'(id_pc), 32'h43);

    // Invalid fetch retains pending delay slot
    fetch(30'h50, 32'h10000003, 1'b1); step();
    branch_bubble = 1'b1; step();
    branch_bubble = 1'b0;
    fetch(30'h52, 32'h20080001, 1'b0); step();
    chk("ifv0_valid", 32'(id_valid), 32'h0);
    chk("ifv0_instr", id_instr, 32'h0);
    chk("ifv0_pc",    32'(id_pc), 32'h52);
    fetch(30'h53, 32'h20080002, 1'b1); step();
    chk("ifv0_ds",  32'(id_in_ds), 32'h1);
    chk("ifv0_bub", 32'(bubble_cnt), 32'h6);

    // Counter saturation
    reset = 1'b1; step();
    chk("rst2_stall",  32'(stall_cnt), 32'h0);
    chk("rst2_bubble", 32'(bubble_cnt), 32'h0);
    reset = 1'b0; hazard = 1'b1;
    repeat (65534) step();
    chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    repeat (3) step();
    chk("sat_ffff",   32'(stall_cnt), 32'hFFFF);
    chk("sat_bubble", 32'(bubble_cnt), 32'h0);

    // Reset mid-HOLD returns to RUN
    reset = 1'b1; step();
    chk("rst_hold_stall", 32'(stall_cnt), 32'h0);
    chk("rst_hold_pc",    32'(id_pc), 32'h0D);
    reset = 1'b0; hazard = 1'b0;
    fetch(30'h60, 32'h20080003, 1'b1); step();
    chk("rst_hold_run", 32'(id_valid), 32'h1);

    // Reset mid-FLUSH returns to RUN
    cp0_bubble = 1'b1; step();
    cp0_bubble = 1'b0; reset = 1'b1; step();
    chk("rst_flush_bubble", 32'(bubble_cnt), 32'h0);
    reset = 1'b0;
    fetch(30'h61, 32'h20080004, 1'b1); step();
    chk("rst_flush_run", 32'(id_valid), 32'h1);
    chk("rst_flush_pc",  32'(id_pc), 32'h61);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
